program_loader: RTL

Upstream stage of the 4-bit CPU. It owns the 16-word instruction memory, fills it from a byte stream on request, and serves instruction fetches to the CPU. While a program is loading or a load has failed, it holds the CPU in reset through its own active-low reset output.

---
 rtl/program_loader_pkg.sv | 31 +++
 rtl/program_loader_mem.sv | 35 +++
 rtl/program_loader.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/program_loader_pkg.sv
// Shared types for the instruction-memory loader of the 4-bit CPU.
// Optional checksum stage: define LOADER_CHECKSUM_EN.
package program_loader_pkg;

  localparam int LOADER_DEPTH = 16;
  localparam int ADDR_W = $clog2(LOADER_DEPTH);

  typedef logic [ADDR_W-1:0] addr_t;

  typedef struct packed {
    logic [3:0] opcode;
    logic [3:0] imm;
  } data_t;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    LOAD,
    CHECK,
    RUN,
    ERROR
  } loader_state_t;

  function automatic logic len_ok(
    input logic [7:0] l
  );
    return (l != 8'd0) &&
           (l <= 8'(LOADER_DEPTH));
  endfunction

endpackage

// File: rtl/program_loader_mem.sv
// Instruction register file: one sync write port,
// sync clear-all, async read.
module loader_mem
  import program_loader_pkg::*;
#(
  parameter int DEPTH = LOADER_DEPTH,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          clear,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  data_t         wdata,
  input  logic [AW-1:0] raddr,
  output data_t         rdata
);

  data_t mem [DEPTH];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else if (clear) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/program_loader.sv
// Loads the CPU program from a byte stream and serves fetches.
// Optional trailing checksum byte: define LOADER_CHECKSUM_EN.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int DEPTH = LOADER_DEPTH
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       load_start,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  input  logic [3:0] fetch_addr,
  output logic [7:0] fetch_data,
  output logic       cpu_reset,
  output logic       busy,
  output logic       error
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  loader_state_t state, state_n;

  logic [AW-1:0] index;
  logic [CW-1:0] count;
  logic          xfer;
  logic          mem_we;
  logic          mem_clr;
  data_t         rdata;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] sum;
`endif

  assign xfer = rx_valid & rx_ready;

  always_comb begin
    state_n = state;
    mem_we  = 1'b0;
    mem_clr = 1'b0;
    if (load_start) begin
      // A new load wins over any byte in flight.
      state_n = LEN;
      mem_clr = 1'b1;
    end else begin
      unique case (state)
        LEN: begin
          if (xfer) begin
            if (len_ok(rx_data)) begin
              state_n = LOAD;
            end else begin
              state_n = ERROR;
              mem_clr = 1'b1;
            end
          end
        end
        LOAD: begin
          if (xfer) begin
            mem_we = 1'b1;
            if (count == CW'(1)) begin
`ifdef LOADER_CHECKSUM_EN
              state_n = CHECK;
`else
              state_n = RUN;
`endif
            end
          end
        end
`ifdef LOADER_CHECKSUM_EN
        CHECK: begin
          if (xfer) begin
            if (8'(sum + rx_data) == 8'd0) begin
              state_n = RUN;
            end else begin
              state_n = ERROR;
              mem_clr = 1'b1;
            end
          end
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      rx_ready  <= 1'b0;
      busy      <= 1'b0;
      error     <= 1'b0;
      cpu_reset <= 1'b0;
    end else begin
      state     <= state_n;
      rx_ready  <= state_n inside {LEN, LOAD, CHECK};
      busy      <= state_n inside {LEN, LOAD, CHECK};
      error     <= state_n == ERROR;
      cpu_reset <= state_n == RUN;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      index <= '0;
      count <= '0;
    end else if (load_start) begin
      index <= '0;
      count <= '0;
    end else if (xfer && state == LEN) begin
      count <= rx_data[CW-1:0];
    end else if (xfer && state == LOAD) begin
      index <= index + AW'(1);
      count <= count - CW'(1);
    end
  end

`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sum <= '0;
    end else if (load_start) begin
      sum <= '0;
    end else if (xfer && state == LEN) begin
      sum <= rx_data;
    end else if (xfer && state == LOAD) begin
      sum <= sum + rx_data;
    end
  end
`endif

  loader_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clock (clock),
    .reset (reset),
    .clear (mem_clr),
    .we    (mem_we),
    .waddr (index),
    .wdata (data_t'(rx_data)),
    .raddr (fetch_addr),
    .rdata (rdata)
  );

  assign fetch_data = rdata;

endmodule
